// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: 4-stage YCbCr to RGB converter with runtime coefficients, saturation and blanking.
// Define YCBCR2RGB_ROUND_EN for round-half-up; default truncates toward minus infinity.
module ycbcr2rgb (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [17:0] k_rcr_i,
  input  logic signed [17:0] k_gcb_i,
  input  logic signed [17:0] k_gcr_i,
  input  logic signed [17:0] k_bcb_i,
  input  logic               dv_i,
  input  logic               hs_i,
  input  logic               vs_i,
  input  logic        [7:0]  y_i,
  input  logic        [7:0]  cb_i,
  input  logic        [7:0]  cr_i,
  output logic               dv_o,
  output logic               hs_o,
  output logic               vs_o,
  output logic        [7:0]  r_o,
  output logic        [7:0]  g_o,
  output logic        [7:0]  b_o
);
`ifdef YCBCR2RGB_ROUND_EN
  localparam logic signed [28:0] RND = 29'sd16384;
`else
  localparam logic signed [28:0] RND = 29'sd0;
`endif
  logic [3:0][2:0] fr;
  logic [7:0] y1, y2;
  logic signed [8:0] cbd1, crd1;
  logic signed [17:0] krcr1, kgcb1, kgcr1, kbcb1;
  logic signed [26:0] pr2, pgb2, pgr2, pb2;
  logic signed [28:0] sr3, sg3, sb3, ys2;
  function automatic logic [7:0] sat(input logic signed [28:0] s);
    return s[28] ? 8'd0 : (|s[27:23]) ? 8'd255 : s[22:15];
  endfunction
  assign ys2 = {6'd0, y2, 15'd0};
  assign {dv_o, hs_o, vs_o} = fr[3];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fr <= '0;
      y1 <= '0;
      y2 <= '0;
      cbd1 <= '0;
      crd1 <= '0;
      krcr1 <= '0;
      kgcb1 <= '0;
      kgcr1 <= '0;
      kbcb1 <= '0;
      pr2 <= '0;
      pgb2 <= '0;
      pgr2 <= '0;
      pb2 <= '0;
      sr3 <= '0;
      sg3 <= '0;
      sb3 <= '0;
      r_o <= '0;
      g_o <= '0;
      b_o <= '0;
    end else begin
      fr <= {fr[2:0], {dv_i, hs_i, vs_i}};
      y1 <= y_i;
      cbd1 <= $signed({1'b0, cb_i}) - 9'sd128;
      crd1 <= $signed({1'b0, cr_i}) - 9'sd128;
      krcr1 <= k_rcr_i;
      kgcb1 <= k_gcb_i;
      kgcr1 <= k_gcr_i;
      kbcb1 <= k_bcb_i;
      y2 <= y1;
      pr2 <= 27'(crd1) * 27'(krcr1);
      pgb2 <= 27'(cbd1) * 27'(kgcb1);
      pgr2 <= 27'(crd1) * 27'(kgcr1);
      pb2 <= 27'(cbd1) * 27'(kbcb1);
      sr3 <= ys2 + 29'(pr2) + RND;
      sg3 <= ys2 - 29'(pgb2) - 29'(pgr2) + RND;
      sb3 <= ys2 + 29'(pb2) + RND;
      // blanking keyed to the dv that travels alongside this stage
      r_o <= fr[2][2] ? sat(sr3) : 8'd0;
      g_o <= fr[2][2] ? sat(sg3) : 8'd0;
      b_o <= fr[2][2] ? sat(sb3) : 8'd0;
    end
endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb_ycbcr2rgb: directed and reset-mid-stream checks for ycbcr2rgb with BT.601 coefficients.
module tb_ycbcr2rgb;
`ifdef YCBCR2RGB_ROUND_EN
  localparam int RND = 16384;
`else
  localparam int RND = 0;
`endif
  logic clk = 0;
  logic rst_n = 0;
  logic signed [17:0] k_rcr_i = 18'sd45941;
  logic signed [17:0] k_gcb_i = 18'sd11277;
  logic signed [17:0] k_gcr_i = 18'sd23401;
  logic signed [17:0] k_bcb_i = 18'sd58065;
  logic dv_i, hs_i, vs_i, dv_o, hs_o, vs_o;
  logic [7:0] y_i, cb_i, cr_i, r_o, g_o, b_o;
  int errors = 0;
  int checks = 0;
  logic [26:0] ex [0:63];
  int n, base;
  ycbcr2rgb dut (
    .clk(clk), .rst_n(rst_n),
    .k_rcr_i(k_rcr_i), .k_gcb_i(k_gcb_i), .k_gcr_i(k_gcr_i), .k_bcb_i(k_bcb_i),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .y_i(y_i), .cb_i(cb_i), .cr_i(cr_i),
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic px(input logic dv, input logic hs, input logic vs,
                    input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
    dv_i = dv;
    hs_i = hs;
    vs_i = vs;
    y_i = y;
    cb_i = cb;
    cr_i = cr;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) px(0, 0, 0, 8'd0, 8'd0, 8'd0);
  endtask
  function automatic logic [7:0] sat8(input int s);
    int v;
    v = s >>> 15;
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction
  function automatic logic [23:0] model(input int y, input int cb, input int cr);
    int cbd, crd, ys;
    cbd = cb - 128;
    crd = cr - 128;
    ys = y * 32768;
    return {sat8(ys + crd * 45941 + RND), sat8(ys - cbd * 11277 - crd * 23401 + RND),
            sat8(ys + cbd * 58065 + RND)};
  endfunction
  initial begin
    logic [23:0] rnd_exp;
    rnd_exp = (RND != 0) ? 24'h676364 : 24'h666264;
    dv_i = 1; hs_i = 0; vs_i = 0; y_i = 200; cb_i = 50; cr_i = 60;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {r_o, g_o, b_o}, 0);
    chk("rst_frame", {dv_o, hs_o, vs_o}, 0);
    dv_i = 0;
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("rel_rgb", {r_o, g_o, b_o}, 0);
    chk("rel_frame", {dv_o, hs_o, vs_o}, 0);
    idle(2);
    px(1, 0, 0, 8'd128, 8'd128, 8'd128);
    idle(2);
    chk("lat_dv_early", dv_o, 0);
    idle(1);
    chk("grey_dv", dv_o, 1);
    chk("grey_rgb", {r_o, g_o, b_o}, 24'h808080);
    px(1, 0, 0, 8'd255, 8'd128, 8'd255);
    idle(3);
    chk("sat_high", {r_o, g_o, b_o}, 24'hFFA4FF);
    px(1, 0, 0, 8'd0, 8'd0, 8'd0);
    idle(3);
    chk("sat_low", {r_o, g_o, b_o}, 24'h008700);
    px(1, 0, 0, 8'd100, 8'd128, 8'd130);
    idle(3);
    chk("rounding", {r_o, g_o, b_o}, rnd_exp);
    px(1, 0, 0, 8'd128, 8'd128, 8'd128);
    px(0, 1, 0, 8'd200, 8'd50, 8'd60);
    px(1, 0, 0, 8'd100, 8'd128, 8'd130);
    px(1, 0, 1, 8'd255, 8'd128, 8'd255);
    chk("frm0_f", {dv_o, hs_o, vs_o}, 3'b100);
    chk("frm0_rgb", {r_o, g_o, b_o}, 24'h808080);
    idle(1);
    chk("frm1_f", {dv_o, hs_o, vs_o}, 3'b010);
    chk("frm1_blank", {r_o, g_o, b_o}, 0);
    idle(1);
    chk("frm2_f", {dv_o, hs_o, vs_o}, 3'b100);
    chk("frm2_rgb", {r_o, g_o, b_o}, rnd_exp);
    idle(1);
    chk("frm3_f", {dv_o, hs_o, vs_o}, 3'b101);
    chk("frm3_rgb", {r_o, g_o, b_o}, 24'hFFA4FF);
    idle(4);
    chk("drain", {dv_o, hs_o, vs_o, r_o, g_o, b_o}, 0);
    n = 0;
    base = 0;
    for (int t = 0; t < 40; t++) begin
      dv_i = ($urandom_range(0, 3) != 0);
      hs_i = 1'($urandom);
      vs_i = 1'($urandom);
      y_i = 8'($urandom);
      cb_i = 8'($urandom);
      cr_i = 8'($urandom);
      n++;
      ex[n] = {dv_i, hs_i, vs_i, dv_i ? model(y_i, cb_i, cr_i) : 24'd0};
      if (t == 20) begin
        rst_n = 0;
        #1;
        chk("rst_async", {dv_o, hs_o, vs_o, r_o, g_o, b_o}, 0);
        base = n;
      end
      if (t == 21) rst_n = 1;
      @(posedge clk);
      #1;
      if (n - 3 > base) chk("rand", {dv_o, hs_o, vs_o, r_o, g_o, b_o}, ex[n - 3]);
      else chk("rand_flush", {dv_o, hs_o, vs_o, r_o, g_o, b_o}, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
